// File: rtl/emul_scheduler_pkg.sv
// Shared types and widths for the EMUL pass scheduler and its result FIFO.
package emul_scheduler_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  localparam int EMUL_LANES = 4;
  localparam int BEAT_W     = 64;
  localparam int RES_W      = 128;
endpackage

// File: rtl/emul_result_fifo.sv
// Result FIFO with a registered head; an empty FIFO forwards a push straight into the head.
module emul_result_fifo
  import emul_scheduler_pkg::*;
#(
  parameter int WIDTH = RES_W,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      scnt;
  logic [AW:0]      total;
  logic             head_vld;
  logic             head_free, push_ok, take_mem, push_mem;

  // Occupancy counts the head register plus the entries queued behind it.
  always_comb begin
    total     = scnt + {{AW{1'b0}}, head_vld};
    full      = (total == (AW+1)'(DEPTH));
    empty     = !head_vld;
    head_free = !head_vld || pop;
    push_ok   = push && (!full || pop);
    take_mem  = head_free && (scnt != '0);
    push_mem  = push_ok && !(head_free && (scnt == '0));
  end

  always_ff @(posedge clk) begin
    if (push_mem) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      scnt      <= '0;
      head_vld  <= 1'b0;
      head_data <= '0;
    end else begin
      if (push_mem) wptr <= wptr + 1'b1;
      if (take_mem) rptr <= rptr + 1'b1;
      case ({push_mem, take_mem})
        2'b10:   scnt <= scnt + 1'b1;
        2'b01:   scnt <= scnt - 1'b1;
        default: ;
      endcase
      if (head_free) begin
        head_vld <= take_mem || push_ok;
        if (take_mem)     head_data <= mem[rptr];
        else if (push_ok) head_data <= push_data;
      end
    end
  end
endmodule

// File: rtl/emul_scheduler.sv
// Sequences one element-wise bf16 multiply pass: operand fetch, EMUL feed, credit-guarded result write-back.
module emul_scheduler
  import emul_scheduler_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 2,
  parameter int MUL_LAT    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [ADDR_W-1:0] cfg_b_base,
  input  logic [ADDR_W-1:0] cfg_r_base,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              a_rd_en,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic [ADDR_W-1:0] b_rd_addr,
  input  logic [BEAT_W-1:0] a_rd_data,
  input  logic [BEAT_W-1:0] b_rd_data,
  output logic              emul_stage_start,
  output logic              emul_a_tvalid,
  output logic              emul_b_tvalid,
  output logic [BEAT_W-1:0] emul_a_tdata,
  output logic [BEAT_W-1:0] emul_b_tdata,
  input  logic              emul_result_tvalid,
  input  logic [RES_W-1:0]  emul_result_tdata,
  output logic              r_wr_valid,
  input  logic              r_wr_ready,
  output logic [ADDR_W-1:0] r_wr_addr,
  output logic [RES_W-1:0]  r_wr_data
);
  if (RD_LAT < 1 || FIFO_DEPTH < RD_LAT + MUL_LAT + 2) begin : g_cfg_check
    $error("emul_scheduler: RD_LAT must be >= 1 and FIFO_DEPTH >= RD_LAT+MUL_LAT+2");
  end

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] a_base, b_base, r_base;
  logic [LEN_W:0]    issue_idx, rd_cnt, wr_cnt, wr_cnt_nxt, inflight, len_x;
  logic [RD_LAT-1:0] vld_p;
  logic              rd_en, tvalid, wr_fire, fifo_full, fifo_empty, overflow;

  // Issue stage: one read per cycle while the pass has credit left.
  always_comb begin
    len_x      = {1'b0, len};
    inflight   = issue_idx - wr_cnt;
    rd_en      = (state == ST_ISSUE) && (issue_idx != len_x) &&
                 (inflight < (LEN_W+1)'(FIFO_DEPTH));
    tvalid     = vld_p[RD_LAT-1];
    wr_fire    = r_wr_valid && r_wr_ready;
    wr_cnt_nxt = wr_cnt + (LEN_W+1)'(wr_fire);
    overflow   = emul_result_tvalid && fifo_full && !wr_fire;
  end

  assign a_rd_en       = rd_en;
  assign b_rd_en       = rd_en;
  assign a_rd_addr     = a_base + ADDR_W'(issue_idx);
  assign b_rd_addr     = b_base + ADDR_W'(issue_idx);
  assign emul_a_tvalid = tvalid;
  assign emul_b_tvalid = tvalid;
  assign emul_a_tdata  = {BEAT_W{tvalid}} & a_rd_data;
  assign emul_b_tdata  = {BEAT_W{tvalid}} & b_rd_data;
  assign r_wr_valid    = !fifo_empty;
  assign r_wr_addr     = r_base + ADDR_W'(wr_cnt);

  // Read-latency stage: rd_en travels alongside the memory read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_overflow     <= 1'b0;
      emul_stage_start <= 1'b0;
      len              <= '0;
      a_base           <= '0;
      b_base           <= '0;
      r_base           <= '0;
      issue_idx        <= '0;
      rd_cnt           <= '0;
      wr_cnt           <= '0;
    end else begin
      done   <= 1'b0;
      wr_cnt <= wr_cnt_nxt;
      if (rd_en)    issue_idx    <= issue_idx + 1'b1;
      if (tvalid)   rd_cnt       <= rd_cnt + 1'b1;
      if (overflow) err_overflow <= 1'b1;
      case (state)
        ST_IDLE: if (cfg_start) begin
          len          <= cfg_len;
          a_base       <= cfg_a_base;
          b_base       <= cfg_b_base;
          r_base       <= cfg_r_base;
          issue_idx    <= '0;
          rd_cnt       <= '0;
          wr_cnt       <= '0;
          err_overflow <= 1'b0;
          if (cfg_len == '0) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end else begin
            state            <= ST_PRIME;
            busy             <= 1'b1;
            emul_stage_start <= 1'b1;
          end
        end
        ST_PRIME: state <= ST_ISSUE;
        ST_ISSUE: if (issue_idx == len_x) state <= ST_DRAIN;
        ST_DRAIN: begin
          // Release EMUL once the last operand beat has left its input registers.
          if (rd_cnt == len_x && vld_p == '0) emul_stage_start <= 1'b0;
          if (wr_cnt_nxt == len_x) begin
            state            <= ST_FINISH;
            busy             <= 1'b0;
            done             <= 1'b1;
            emul_stage_start <= 1'b0;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  emul_result_fifo #(.WIDTH(RES_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (emul_result_tvalid),
    .push_data (emul_result_tdata),
    .pop       (wr_fire),
    .head_data (r_wr_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_emul_scheduler.sv
// Randomized bench for emul_scheduler with memory, EMUL and bf16 reference models.
module tb_emul_scheduler;
  localparam int ADDR_W = 16, LEN_W = 16, RD_LAT = 2, MUL_LAT = 8, FIFO_DEPTH = 16;
  localparam int FIRST_WR = 2 + RD_LAT + MUL_LAT + 2;

  logic clk, rst, cfg_start;
  logic [LEN_W-1:0] cfg_len;
  logic [ADDR_W-1:0] cfg_a_base, cfg_b_base, cfg_r_base;
  logic busy, done, err_overflow, a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr, r_wr_addr;
  logic [63:0] a_rd_data, b_rd_data, emul_a_tdata, emul_b_tdata;
  logic emul_stage_start, emul_a_tvalid, emul_b_tvalid, emul_result_tvalid;
  logic [127:0] emul_result_tdata, r_wr_data;
  logic r_wr_valid, r_wr_ready;

  int checks = 0, errors = 0, cyc = 0;

  emul_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_r_base(cfg_r_base),
    .busy(busy), .done(done), .err_overflow(err_overflow),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .emul_stage_start(emul_stage_start),
    .emul_a_tvalid(emul_a_tvalid), .emul_b_tvalid(emul_b_tvalid),
    .emul_a_tdata(emul_a_tdata), .emul_b_tdata(emul_b_tdata),
    .emul_result_tvalid(emul_result_tvalid), .emul_result_tdata(emul_result_tdata),
    .r_wr_valid(r_wr_valid), .r_wr_ready(r_wr_ready), .r_wr_addr(r_wr_addr),
    .r_wr_data(r_wr_data)
  );

  wire [511:0] all_out = {busy, done, err_overflow, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
                          emul_stage_start, emul_a_tvalid, emul_b_tvalid, emul_a_tdata,
                          emul_b_tdata, r_wr_valid, r_wr_addr, r_wr_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact bf16 x bf16 -> fp32 for normal operands (product mantissa fits in 24 bits).
  function automatic logic [31:0] bf16_mul(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] p; logic [8:0] e; logic [22:0] m;
    p = {8'd0, 1'b1, x[6:0]} * {8'd0, 1'b1, y[6:0]};
    e = {1'b0, x[14:7]} + {1'b0, y[14:7]} - 9'd127;
    if (p[15]) begin e = e + 9'd1; m = {p[14:0], 8'd0}; end
    else m = {p[13:0], 9'd0};
    return {x[15] ^ y[15], e[7:0], m};
  endfunction

  function automatic logic [127:0] beat_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = bf16_mul(a[16*i +: 16], b[16*i +: 16]);
    return r;
  endfunction

  function automatic logic [63:0] rand_beat();
    logic [63:0] v;
    v = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) v[16*i+13 +: 2] = 2'b01;
    return v;
  endfunction

  logic [63:0] mem_a [0:65535];
  logic [63:0] mem_b [0:65535];
  logic [63:0] rpa [RD_LAT];
  logic [63:0] rpb [RD_LAT];
  always @(posedge clk) begin
    rpa[0] <= mem_a[a_rd_addr];
    rpb[0] <= mem_b[b_rd_addr];
    for (int k = 1; k < RD_LAT; k++) begin rpa[k] <= rpa[k-1]; rpb[k] <= rpb[k-1]; end
  end
  assign a_rd_data = rpa[RD_LAT-1];
  assign b_rd_data = rpb[RD_LAT-1];

  logic ev [MUL_LAT+1];
  logic [127:0] ed [MUL_LAT+1];
  always @(posedge clk) begin
    ev[0] <= emul_a_tvalid;
    ed[0] <= beat_mul(emul_a_tdata, emul_b_tdata);
    for (int k = 1; k <= MUL_LAT; k++) begin ev[k] <= ev[k-1]; ed[k] <= ed[k-1]; end
  end
  assign emul_result_tvalid = ev[MUL_LAT];
  assign emul_result_tdata  = ed[MUL_LAT];

  int rd_q[$]; logic [15:0] rda_q[$]; logic [15:0] wa_q[$]; logic [127:0] wd_q[$];
  int wc_q[$]; int done_q[$];
  int busy_n, busy_first, busy_last, ss_n, ss_first, bad_tv, en_mis, issued, written, infl_max;

  always @(negedge clk) begin
    int infl;
    if (a_rd_en) begin rd_q.push_back(cyc); rda_q.push_back(a_rd_addr); end
    if (r_wr_valid && r_wr_ready) begin
      wa_q.push_back(r_wr_addr); wd_q.push_back(r_wr_data); wc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (busy) begin busy_n++; busy_last = cyc; if (busy_first < 0) busy_first = cyc; end
    if (emul_stage_start) begin ss_n++; if (ss_first < 0) ss_first = cyc; end
    if (emul_a_tvalid && !emul_stage_start) bad_tv++;
    if (a_rd_en !== b_rd_en || emul_a_tvalid !== emul_b_tvalid) en_mis++;
    infl = issued + int'(a_rd_en) - written;
    if (infl > infl_max) infl_max = infl;
    issued  += int'(a_rd_en);
    written += int'(r_wr_valid && r_wr_ready);
  end

  task automatic clear_mon();
    rd_q.delete(); rda_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete(); done_q.delete();
    busy_n = 0; busy_first = -1; busy_last = -1; ss_n = 0; ss_first = -1;
    bad_tv = 0; en_mis = 0; issued = 0; written = 0; infl_max = 0;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0: r_wr_ready = 1'b1;
      1: r_wr_ready = (cyc % 4 == 0);
      2: r_wr_ready = 1'b0;
      default: r_wr_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_pass(input int len, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input int mode, output int s, output bit to);
    int n;
    @(posedge clk); #1;
    clear_mon();
    cfg_len = LEN_W'(len); cfg_a_base = a; cfg_b_base = b; cfg_r_base = r;
    cfg_start = 1'b1; s = cyc; set_ready(mode);
    @(posedge clk); #1;
    cfg_start = 1'b0;
    n = 0;
    while (done_q.size() == 0 && n < 4000) begin
      set_ready(mode); @(posedge clk); #1; n++;
    end
    to = (done_q.size() == 0);
    r_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_start = 0; cfg_len = 0; cfg_a_base = 0; cfg_b_base = 0; cfg_r_base = 0;
    r_wr_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got %h want 0", all_out); end
  endtask

  task automatic test_single();
    int s; bit to; logic [127:0] exp;
    run_pass(1, 16'h0000, 16'h0010, 16'h0020, 0, s, to);
    exp = beat_mul(mem_a[16'h0000], mem_b[16'h0010]);
    checks++; if (to) begin errors++; $display("FAIL single_timeout no done"); end
    checks++;
    if (rd_q.size() != 1 || rd_q[0] != s + 2) begin
      errors++; $display("FAIL single_rd_cycle got n=%0d c=%0d want c=%0d", rd_q.size(),
                         rd_q.size() ? rd_q[0] - s : -1, 2);
    end
    checks++;
    if (wa_q.size() != 1) begin errors++; $display("FAIL single_wr_count got %0d want 1", wa_q.size()); end
    else begin
      checks++; if (wa_q[0] !== 16'h0020) begin errors++; $display("FAIL single_wr_addr got %h want 0020", wa_q[0]); end
      checks++; if (wd_q[0] !== exp) begin errors++; $display("FAIL single_wr_data got %h want %h", wd_q[0], exp); end
      checks++; if (wc_q[0] != s + FIRST_WR) begin errors++; $display("FAIL single_wr_cycle got %0d want %0d", wc_q[0] - s, FIRST_WR); end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != s + FIRST_WR + 1) begin
      errors++; $display("FAIL single_done got n=%0d c=%0d want c=%0d", done_q.size(),
                         done_q.size() ? done_q[0] - s : -1, FIRST_WR + 1);
    end
    checks++;
    if (busy_first != s + 1 || busy_last != s + FIRST_WR || busy_n != FIRST_WR) begin
      errors++; $display("FAIL single_busy got first=%0d last=%0d n=%0d want 1 %0d %0d",
                         busy_first - s, busy_last - s, busy_n, FIRST_WR, FIRST_WR);
    end
    checks++; if (ss_first != s + 1) begin errors++; $display("FAIL single_stage_start got %0d want 1", ss_first - s); end
  endtask

  task automatic test_full_rate();
    int s; bit to; logic [15:0] a, b, r; int bad;
    a = 16'($urandom); b = 16'($urandom); r = 16'h0020;
    run_pass(64, a, b, r, 0, s, to);
    checks++; if (to) begin errors++; $display("FAIL full_timeout no done"); end
    checks++;
    if (rd_q.size() != 64 || rd_q[0] != s + 2 || rd_q[63] - rd_q[0] != 63) begin
      errors++; $display("FAIL full_rd_contig got n=%0d want 64 contiguous from cycle 2", rd_q.size());
    end
    checks++;
    if (wa_q.size() != 64) begin errors++; $display("FAIL full_wr_count got %0d want 64", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 64; i++) begin
      logic [15:0] ea; logic [127:0] exp;
      ea = r + 16'(i); exp = beat_mul(mem_a[a + 16'(i)], mem_b[b + 16'(i)]);
      checks++;
      if (wa_q[i] !== ea || wd_q[i] !== exp) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL full_wr[%0d] got %h/%h want %h/%h", i, wa_q[i], wd_q[i], ea, exp);
      end
    end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b want 0", err_overflow); end
    checks++;
    if (bad_tv != 0 || en_mis != 0) begin
      errors++; $display("FAIL full_strobes got tv_no_stage=%0d a_b_mismatch=%0d want 0 0", bad_tv, en_mis);
    end
  endtask

  task automatic test_backpressure();
    int s; bit to; logic [15:0] a, b, r; int bad;
    a = 16'($urandom); b = 16'($urandom); r = 16'($urandom);
    run_pass(64, a, b, r, 1, s, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout no done"); end
    checks++;
    if (wa_q.size() != 64 || rd_q.size() != 64) begin
      errors++; $display("FAIL bp_count got wr=%0d rd=%0d want 64 64", wa_q.size(), rd_q.size());
    end
    bad = 0;
    for (int i = 0; i < wa_q.size() && i < 64; i++) begin
      logic [15:0] ea; logic [127:0] exp;
      ea = r + 16'(i); exp = beat_mul(mem_a[a + 16'(i)], mem_b[b + 16'(i)]);
      checks++;
      if (wa_q[i] !== ea || wd_q[i] !== exp) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL bp_wr[%0d] got %h/%h want %h/%h", i, wa_q[i], wd_q[i], ea, exp);
      end
    end
    checks++; if (infl_max != FIFO_DEPTH) begin errors++; $display("FAIL bp_inflight_max got %0d want %0d", infl_max, FIFO_DEPTH); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b want 0", err_overflow); end
  endtask

  task automatic test_zero_len();
    int s; bit to;
    run_pass(0, 16'h1234, 16'h5678, 16'h9abc, 0, s, to);
    checks++;
    if (to || done_q[0] != s + 1) begin
      errors++; $display("FAIL zero_done got %0d want 1", to ? -1 : done_q[0] - s);
    end
    checks++;
    if (rd_q.size() != 0 || ss_n != 0 || wa_q.size() != 0) begin
      errors++; $display("FAIL zero_activity got rd=%0d stage=%0d wr=%0d want 0 0 0", rd_q.size(), ss_n, wa_q.size());
    end
  endtask

  task automatic test_ignore_start_reset();
    @(posedge clk); #1;
    clear_mon();
    r_wr_ready = 1'b0;
    cfg_len = 16'd12; cfg_a_base = 16'h0100; cfg_b_base = 16'h0200; cfg_r_base = 16'h0300;
    cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    repeat (4) @(posedge clk); #1;
    cfg_len = 16'd5; cfg_a_base = 16'h0500; cfg_b_base = 16'h0600; cfg_r_base = 16'h0700;
    cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;
    repeat (40) @(posedge clk); #1;
    checks++;
    if (rd_q.size() != 12 || rda_q[rda_q.size()-1] !== 16'h010b) begin
      errors++; $display("FAIL ignore_len got rd=%0d want 12 ending at 010b", rd_q.size());
    end
    checks++;
    if (r_wr_valid !== 1'b1 || r_wr_addr !== 16'h0300 || busy !== 1'b1) begin
      errors++; $display("FAIL ignore_hold got valid=%b addr=%h busy=%b want 1 0300 1", r_wr_valid, r_wr_addr, busy);
    end
    rst = 1'b1; #1;
    checks++;
    if (all_out !== '0) begin errors++; $display("FAIL abort_outputs got %h want 0", all_out); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0; r_wr_ready = 1'b1;
    repeat (15) @(posedge clk); #1;
    checks++;
    if (done_q.size() != 0 || wa_q.size() != 0 || all_out !== '0) begin
      errors++; $display("FAIL abort_quiet got done=%0d wr=%0d out=%h want 0 0 0", done_q.size(), wa_q.size(), all_out);
    end
  endtask

  task automatic test_addr_wrap();
    int s; bit to; logic [15:0] a, b;
    a = 16'hFFFD; b = 16'($urandom);
    run_pass(4, a, b, 16'hFFFE, 3, s, to);
    checks++; if (to || wa_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 4; i++) begin
      logic [15:0] ea; logic [127:0] exp;
      ea = 16'hFFFE + 16'(i); exp = beat_mul(mem_a[a + 16'(i)], mem_b[b + 16'(i)]);
      checks++;
      if (wa_q[i] !== ea || wd_q[i] !== exp) begin
        errors++; $display("FAIL wrap_wr[%0d] got %h/%h want %h/%h", i, wa_q[i], wd_q[i], ea, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin mem_a[i] = rand_beat(); mem_b[i] = rand_beat(); end
    test_reset();
    test_single();
    test_full_rate();
    test_backpressure();
    test_zero_len();
    test_ignore_start_reset();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
